// File: rtl/v_pkg.sv
// Shared definitions for the element-serial vector execute stage:
// element geometry, ALU op encoding and the sequencer FSM state type.
package v_pkg;

  localparam int unsigned XLEN   = 32;  // element width in bits
  localparam int unsigned MAX_VL = 10;  // elements per vector register
  localparam int unsigned IDX_W  = 4;   // ele_index / vl width, 2^IDX_W > MAX_VL

  localparam logic [2:0] VOP_ADD = 3'd0;
  localparam logic [2:0] VOP_SUB = 3'd1;  // vs1 - vs2
  localparam logic [2:0] VOP_AND = 3'd2;
  localparam logic [2:0] VOP_OR  = 3'd3;
  localparam logic [2:0] VOP_XOR = 3'd4;
  localparam logic [2:0] VOP_SLL = 3'd5;
  localparam logic [2:0] VOP_SRL = 3'd6;
  localparam logic [2:0] VOP_SRA = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StFin
  } seq_state_e;

endpackage

// File: rtl/v_elem_sequencer_if.sv
// Bus bundle between the vector sequencer and its neighbours: the instruction
// valid/ready handshake, status flags, and the register-file element port.
//   master : the sequencer (drives in_ready, status, rf_* / ele_index / stg_en /
//            v_write / vw_data; receives the instruction and vs1/vs2 read data)
//   slave  : the instruction source plus register file (opposite directions)
interface v_elem_sequencer_if;
  import v_pkg::*;

  // Instruction handshake
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_vs1;
  logic [4:0]       in_vs2;
  logic [4:0]       in_vd;
  logic [2:0]       in_op;
  logic [IDX_W-1:0] in_vl;

  // Status
  logic             busy;
  logic             done;

  // Register-file element port
  logic [4:0]       rf_vs1;
  logic [4:0]       rf_vs2;
  logic [4:0]       rf_vd;
  logic [IDX_W-1:0] ele_index;
  logic             stg_en;
  logic             v_write;
  logic [XLEN-1:0]  vw_data;
  logic [XLEN-1:0]  vs1_data;
  logic [XLEN-1:0]  vs2_data;

  modport master (
    input  in_valid, in_vs1, in_vs2, in_vd, in_op, in_vl, vs1_data, vs2_data,
    output in_ready, busy, done, rf_vs1, rf_vs2, rf_vd, ele_index, stg_en, v_write,
           vw_data
  );

  modport slave (
    output in_valid, in_vs1, in_vs2, in_vd, in_op, in_vl, vs1_data, vs2_data,
    input  in_ready, busy, done, rf_vs1, rf_vs2, rf_vd, ele_index, stg_en, v_write,
           vw_data
  );

endinterface

// File: rtl/v_elem_alu.sv
// Combinational element ALU.
//   op     : operation select (VOP_* encoding)
//   a, b   : element operands (a = vs1 element, b = vs2 element)
//   result : op(a, b); add/sub wrap, shifts use b[4:0], SRA is arithmetic
module v_elem_alu
  import v_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    unique case (op)
      VOP_ADD: result = a + b;
      VOP_SUB: result = a - b;
      VOP_AND: result = a & b;
      VOP_OR:  result = a | b;
      VOP_XOR: result = a ^ b;
      VOP_SLL: result = a << shamt;
      VOP_SRL: result = a >> shamt;
      VOP_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/v_elem_sequencer.sv
// Element-serial vector execute stage. Accepts one vector-vector instruction,
// then alternates READ / WRITE cycles per element on the register-file port,
// writing ALU(op, vs1[i], vs2[i]) to vd[i] for i = 0 .. vl_eff-1, then pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of v_elem_sequencer_if (handshake, status, RF port)
module v_elem_sequencer
  import v_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  v_elem_sequencer_if.master    bus
);

  localparam logic [IDX_W-1:0] MaxVl = IDX_W'(MAX_VL);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] vl_q, vl_d;
  logic [4:0]       vs1_q, vs1_d;
  logic [4:0]       vs2_q, vs2_d;
  logic [4:0]       vd_q, vd_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  alu_result;

  // Read data is registered in the RF, so during WRITE it already holds element idx.
  v_elem_alu u_alu (
    .op     (op_q),
    .a      (bus.vs1_data),
    .b      (bus.vs2_data),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vl_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vl_q    <= vl_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vl_d         = vl_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    vd_d         = vd_q;
    op_d         = op_q;
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    bus.stg_en   = 1'b0;
    bus.v_write  = 1'b0;
    bus.vw_data  = '0;

    case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          vs1_d   = bus.in_vs1;
          vs2_d   = bus.in_vs2;
          vd_d    = bus.in_vd;
          op_d    = bus.in_op;
          vl_d    = (bus.in_vl > MaxVl) ? MaxVl : bus.in_vl;
          idx_d   = '0;
          state_d = (vl_d == '0) ? StFin : StRead;
        end
      end
      StRead: begin
        bus.stg_en = 1'b1;
        state_d    = StWrite;
      end
      StWrite: begin
        bus.stg_en  = 1'b1;
        bus.v_write = 1'b1;
        bus.vw_data = alu_result;
        if (idx_q + IDX_W'(1) == vl_q) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StRead;
        end
      end
      StFin: begin
        bus.done = 1'b1;
        idx_d    = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.ele_index = idx_q;
  assign bus.rf_vs1    = vs1_q;
  assign bus.rf_vs2    = vs2_q;
  assign bus.rf_vd     = vd_q;

endmodule

// File: tb/tb_v_elem_sequencer.sv
// Directed bench for v_elem_sequencer with a behavioural register file
// (registered read data, write qualified by stg_en && v_write).
module tb_v_elem_sequencer;
  import v_pkg::*;

  logic clk;
  logic rst;
  logic rf_init;

  int checks;
  int pass_cnt;

  v_elem_sequencer_if bus ();

  v_elem_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: 32 vectors, 16 slots each (only 0..MAX_VL-1 used).
  logic [XLEN-1:0] mem [32][16];

  always_ff @(posedge clk) begin
    if (rf_init) begin
      for (int r = 0; r < 32; r++) begin
        for (int e = 0; e < 16; e++) begin
          mem[5'(r)][4'(e)] <= (r == 3) ? 32'd10 : (r == 4) ? 32'd15 : 32'd0;
        end
      end
      bus.vs1_data <= '0;
      bus.vs2_data <= '0;
    end else if (bus.stg_en) begin
      if (bus.v_write) mem[bus.rf_vd][bus.ele_index] <= bus.vw_data;
      bus.vs1_data <= mem[bus.rf_vs1][bus.ele_index];
      bus.vs2_data <= mem[bus.rf_vs2][bus.ele_index];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one instruction and watch it until done (bounded).
  task automatic run_instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input logic [2:0] op, input logic [3:0] vl, input int exp_n,
                           input logic [31:0] exp_data, input string tag);
    int nwr;
    int nstg;
    int done_cyc;
    logic [3:0] max_idx;
    @(negedge clk);
    bus.in_vs1   = s1;
    bus.in_vs2   = s2;
    bus.in_vd    = d;
    bus.in_op    = op;
    bus.in_vl    = vl;
    bus.in_valid = 1'b1;
    check({tag, " ready_at_issue"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    nwr = 0;
    nstg = 0;
    done_cyc = 0;
    max_idx = '0;
    for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (bus.stg_en) begin
        nstg++;
        if (bus.ele_index > max_idx) max_idx = bus.ele_index;
      end
      if (bus.v_write) begin
        check({tag, " wr_idx"}, 32'(bus.ele_index), nwr);
        check({tag, " wr_data"}, bus.vw_data, exp_data);
        nwr++;
      end
      if (bus.done) done_cyc = c;
    end
    check({tag, " write_count"}, nwr, exp_n);
    check({tag, " stg_count"}, nstg, 2 * exp_n);
    check({tag, " done_cycle"}, done_cyc, 2 * exp_n + 1);
    check({tag, " max_idx"}, 32'(max_idx), (exp_n > 0) ? exp_n - 1 : 0);
    @(negedge clk);
    check({tag, " ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_done;
    int second_done;
    int ready_cyc;
    int done_seen;
    int stg_seen;

    checks   = 0;
    pass_cnt = 0;
    rst      = 1'b1;
    rf_init  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vs1   = '0;
    bus.in_vs2   = '0;
    bus.in_vd    = '0;
    bus.in_op    = '0;
    bus.in_vl    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst stg_en", 32'(bus.stg_en), 32'd0);
    check("rst v_write", 32'(bus.v_write), 32'd0);
    check("rst ele_index", 32'(bus.ele_index), 32'd0);
    check("rst rf_vs1", 32'(bus.rf_vs1), 32'd0);
    check("rst rf_vd", 32'(bus.rf_vd), 32'd0);
    check("rst vw_data", bus.vw_data, 32'd0);
    rst     = 1'b0;
    rf_init = 1'b0;

    // ADD 10+15 across a full vector into v5
    run_instr(5'd3, 5'd4, 5'd5, VOP_ADD, 4'd10, 10, 32'd25, "add");
    check("add rf_vd held", 32'(bus.rf_vd), 32'd5);
    for (int e = 0; e < 10; e++) check("add v5", mem[5'd5][4'(e)], 32'd25);

    // SUB 10-15 over 3 elements into v7; the tail stays untouched
    run_instr(5'd3, 5'd4, 5'd7, VOP_SUB, 4'd3, 3, 32'hFFFF_FFFB, "sub");
    for (int e = 0; e < 3; e++) check("sub v7 head", mem[5'd7][4'(e)], 32'hFFFF_FFFB);
    for (int e = 3; e < 10; e++) check("sub v7 tail", mem[5'd7][4'(e)], 32'd0);

    // vl = 0: straight to FIN
    run_instr(5'd3, 5'd4, 5'd6, VOP_ADD, 4'd0, 0, 32'd0, "vl0");
    for (int e = 0; e < 10; e++) check("vl0 v6", mem[5'd6][4'(e)], 32'd0);

    // vl = 15 clamps to MAX_VL; OR 10|15 = 15
    run_instr(5'd3, 5'd4, 5'd8, VOP_OR, 4'd15, 10, 32'd15, "vl15");

    // Reset during the WRITE of element 4 into v9
    @(negedge clk);
    bus.in_vs1   = 5'd3;
    bus.in_vs2   = 5'd4;
    bus.in_vd    = 5'd9;
    bus.in_op    = VOP_ADD;
    bus.in_vl    = 4'd10;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid in_write", 32'(bus.v_write), 32'd1);
    check("rstmid idx", 32'(bus.ele_index), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid ready", 32'(bus.in_ready), 32'd1);
    check("rstmid busy", 32'(bus.busy), 32'd0);
    check("rstmid stg_en", 32'(bus.stg_en), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    stg_seen  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (bus.stg_en) stg_seen++;
    end
    check("rstmid no_done", done_seen, 0);
    check("rstmid no_stg", stg_seen, 0);
    for (int e = 0; e < 4; e++) check("rstmid v9 head", mem[5'd9][4'(e)], 32'd25);
    for (int e = 5; e < 10; e++) check("rstmid v9 tail", mem[5'd9][4'(e)], 32'd0);

    // Back-to-back with in_valid held: ADD into v10, then XOR in place on v3
    @(negedge clk);
    bus.in_vs1   = 5'd3;
    bus.in_vs2   = 5'd4;
    bus.in_vd    = 5'd10;
    bus.in_op    = VOP_ADD;
    bus.in_vl    = 4'd10;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_vd = 5'd3;
    bus.in_op = VOP_XOR;
    first_done  = 0;
    second_done = 0;
    ready_cyc   = 0;
    for (int c = 1; c <= 80 && second_done == 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first_done == 0) first_done = c;
        else second_done = c;
      end
      if (bus.in_ready && ready_cyc == 0) begin
        ready_cyc = c;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
      end
    end
    check("b2b first_done", first_done, 21);
    check("b2b second_accept", ready_cyc, 22);
    check("b2b second_done", second_done, 43);
    for (int e = 0; e < 10; e++) check("b2b v10", mem[5'd10][4'(e)], 32'd25);
    for (int e = 0; e < 10; e++) check("b2b v3 xor", mem[5'd3][4'(e)], 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule

// File: doc/v_elem_sequencer.md
Name: v_elem_sequencer

Overview:
Element-serial vector execute stage that drives the vector register file's per-element read/write port. It accepts one vector-vector instruction (vs1, vs2, vd, op, vl) through a valid/ready handshake. It walks ele_index from 0 to vl-1, reading both source elements, applying the ALU op and writing the result back to vd at the same index. It sits directly upstream of the register file, which has registered read data and a write enable qualified by stg_en.

Parameters:
XLEN, 32, element width in bits
MAX_VL, 10, elements per vector register; must match register-file depth
IDX_W, 4, width of ele_index and vl; must satisfy 2^IDX_W > MAX_VL

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  high only in IDLE
in_vs1  input  5  source register 1
in_vs2  input  5  source register 2
in_vd  input  5  destination register
in_op  input  3  0 ADD, 1 SUB (vs1-vs2), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA; shift amount is vs2[4:0]
in_vl  input  IDX_W  element count
busy  output  1  high while an instruction is in flight
done  output  1  one-cycle pulse when an instruction completes
rf_vs1  output  5  to regfile vs1
rf_vs2  output  5  to regfile vs2
rf_vd  output  5  to regfile v_d
ele_index  output  IDX_W  to regfile ele_index
stg_en  output  1  to regfile stg_en
v_write  output  1  to regfile v_write
vw_data  output  XLEN  to regfile vw_data
vs1_data  input  XLEN  from regfile, valid the cycle after a READ
vs2_data  input  XLEN  from regfile, valid the cycle after a READ

Behaviour:
- Reset (synchronous, rst sampled at posedge): state is IDLE. in_ready=1; busy, done, stg_en and v_write are 0; ele_index=0; rf_* and vw_data are 0. Reset mid-instruction aborts at that edge: no further writes, and done is not pulsed.
- FSM states are IDLE, READ, WRITE and FIN.
- IDLE: in_ready=1. On in_valid&&in_ready, latch vs1, vs2, vd and op, and set vl_eff=min(in_vl,MAX_VL). If vl_eff==0 go to FIN; otherwise go to READ with idx=0.
- READ (1 cycle): stg_en=1, v_write=0, ele_index=idx. The register file captures vs1_data/vs2_data at the end of this cycle. Next state is WRITE.
- WRITE (1 cycle): stg_en=1, v_write=1, ele_index=idx, vw_data=ALU(op, vs1_data, vs2_data), computed combinationally from the register-file outputs. If idx==vl_eff-1 go to FIN; otherwise set idx=idx+1 and go to READ.
- FIN (1 cycle): done=1, stg_en=0. Next state is IDLE.
- Throughput: 2 cycles per element. An instruction with vl_eff=N occupies 2N+1 cycles from the accept edge to done. The next instruction can be accepted in the cycle after done.
- busy=1 in READ, WRITE and FIN.
- stg_en=0 and v_write=0 in IDLE and FIN, so the register-file outputs hold.
- vd aliasing vs1 or vs2 is legal. Each element is read in READ before it is written in WRITE, so no hazard exists.
- Arithmetic: ADD and SUB wrap modulo 2^XLEN. Shifts use vs2_data[4:0] only; SRA is arithmetic. There are no flags.
- in_valid while busy is ignored: in_ready=0 and nothing is latched.
- Outputs rf_vs1, rf_vs2 and rf_vd hold the latched values from accept until the next accept.
- vw_data is don't-care outside WRITE but must not be X; drive it as 0.

Decomposition:
- Shared package v_pkg: the op encoding constants (VOP_ADD..VOP_SRA), XLEN, MAX_VL, IDX_W and the FSM state encoding.
- One sub-module, v_elem_alu: purely combinational, inputs (op, a, b), output result.

Test Plan:
- Reset, then in_valid with vs1=3 (all elements 10), vs2=4 (all 15), vd=5, op=ADD, vl=10 → 10 write pulses at ele_index 0..9 with vw_data=25 each, done exactly 21 cycles after the accept edge, and reg 5 holds all 25.
- op=SUB with vs1=3, vs2=4, vl=3 → vw_data=0xFFFFFFFB at indices 0..2. Indices 3..9 of vd are untouched (read back as 0).
- vl=0 → no stg_en/v_write pulses, done pulses the cycle after accept, and in_ready returns high the next cycle.
- vl=15 → clamped to 10: exactly 10 writes and ele_index never exceeds 9.
- Assert rst during the WRITE of element 4 of a 10-element ADD → writes stop at that edge, done never pulses, elements 5..9 of vd are unchanged, and in_ready=1 one cycle after the reset edge.
- in_valid held high across two back-to-back instructions → the second is accepted only in the cycle after the first's done, and the second's vd=vs1 alias (op=XOR vs1=vd=3, vs2=4) yields 10^15=5 in all elements.
